// File: rtl/seg_message_scroller_if.sv
// Write-side handshake bundle for the seven-segment message scroller.
// The producer drives entries; the scroller answers with wr_ready.
interface seg_message_scroller_if;
  logic       wr_valid;
  logic [6:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_message_scroller.sv
// Eight-entry append-only message buffer shown one entry at a time on a
// seven-segment digit, stepping every PRESCALE*(speed+1) cycles while run is high.
module seg_message_scroller #(
  parameter int PRESCALE = 1000000,
  parameter int DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clear,
  input  logic                  run,
  input  logic [3:0]            speed,
  seg_message_scroller_if.slave wr,
  output logic [6:0]            segments,
  output logic [2:0]            rd_idx,
  output logic [3:0]            count,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HOLD   = 2'd1,
    S_SCROLL = 2'd2
  } state_e;

  localparam logic [23:0] PRE_MAX = 24'(PRESCALE - 1);
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
  logic [23:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]  step_cnt_q, step_cnt_d;
  logic        wrap_q, wrap_d;
  logic [6:0]  seg_q, seg_d;
  logic [6:0]  msg_q [DEPTH];
  logic [6:0]  msg_d [DEPTH];
  logic        accept_s;
  logic        tick_s;
  logic        step_s;

  assign wr.wr_ready = ena & ~clear & (count_q < DEPTH_C);
  assign accept_s    = wr.wr_valid & wr.wr_ready;

  // Next-state: prescaler, step counter, index advance, append and FSM.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    pre_cnt_d  = pre_cnt_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = wrap_q;
    seg_d      = seg_q;
    msg_d      = msg_q;
    tick_s     = 1'b0;
    step_s     = 1'b0;
    if (ena) begin
      // Display lags state/rd_idx by one edge, so it samples the old values.
      seg_d  = (state_q == S_EMPTY) ? 7'd0 : msg_q[rd_idx_q];
      wrap_d = 1'b0;
      if (clear) begin
        count_d    = 4'd0;
        rd_idx_d   = 3'd0;
        pre_cnt_d  = 24'd0;
        step_cnt_d = 4'd0;
        state_d    = S_EMPTY;
      end else begin
        if (state_q == S_SCROLL) begin
          if (pre_cnt_q == PRE_MAX) begin
            pre_cnt_d = 24'd0;
            tick_s    = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 24'd1;
          end
        end else begin
          pre_cnt_d = pre_cnt_q;
        end
        // ">=" recovers cleanly when speed is lowered below the running count.
        if (tick_s) begin
          if (step_cnt_q >= speed) begin
            step_cnt_d = 4'd0;
            step_s     = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + 4'd1;
          end
        end else begin
          step_cnt_d = step_cnt_q;
        end
        if (step_s) begin
          if ({1'b0, rd_idx_q} == (count_q - 4'd1)) begin
            rd_idx_d = 3'd0;
            wrap_d   = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 3'd1;
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
        if (accept_s) begin
          msg_d[count_q[2:0]] = wr.wr_data;
          count_d             = count_q + 4'd1;
        end else begin
          count_d = count_q;
        end
        case (state_q)
          S_EMPTY:  state_d = accept_s ? (run ? S_SCROLL : S_HOLD) : S_EMPTY;
          S_HOLD:   state_d = run ? S_SCROLL : S_HOLD;
          S_SCROLL: state_d = run ? S_SCROLL : S_HOLD;
          default:  state_d = S_EMPTY;
        endcase
      end
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      count_q    <= 4'd0;
      rd_idx_q   <= 3'd0;
      pre_cnt_q  <= 24'd0;
      step_cnt_q <= 4'd0;
      wrap_q     <= 1'b0;
      seg_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      pre_cnt_q  <= pre_cnt_d;
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
    end
  end

  // Message storage; contents survive reset since count gates visibility.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

  assign segments = seg_q;
  assign rd_idx   = rd_idx_q;
  assign count    = count_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_seg_message_scroller.sv
// Randomised and directed bench for seg_message_scroller (PRESCALE=4) against
// a cycle-count reference model of the scrolling message display.
module tb_seg_message_scroller;
  localparam int PRESCALE = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic       run;
  logic [3:0] speed;
  logic [6:0] segments;
  logic [2:0] rd_idx;
  logic [3:0] count;
  logic       wrap;

  seg_message_scroller_if wif ();

  seg_message_scroller #(.PRESCALE(PRESCALE), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clear    (clear),
    .run      (run),
    .speed    (speed),
    .wr       (wif.slave),
    .segments (segments),
    .rd_idx   (rd_idx),
    .count    (count),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: entries list plus "cycles spent scrolling since last step".
  logic [6:0] m_ent [8];
  int         m_cnt;
  int         m_idx;
  int         m_elapsed;
  bit         m_empty;
  bit         m_scroll;
  logic [6:0] m_seg;
  bit         m_wrap;

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_elapsed = 0; m_empty = 1'b1; m_scroll = 1'b0;
    m_seg = 7'd0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    bit step;
    if (!ena) return;
    m_seg  = m_empty ? 7'd0 : m_ent[m_idx];
    m_wrap = 1'b0;
    if (clear) begin
      m_cnt = 0; m_idx = 0; m_elapsed = 0; m_empty = 1'b1; m_scroll = 1'b0;
      return;
    end
    step = 1'b0;
    if (m_scroll) begin
      m_elapsed++;
      if (m_elapsed == PRESCALE * (int'(speed) + 1)) begin
        m_elapsed = 0;
        step = 1'b1;
      end
    end
    if (step) begin
      if (m_idx == m_cnt - 1) begin m_idx = 0; m_wrap = 1'b1; end
      else m_idx++;
    end
    if (wif.wr_valid && m_cnt < 8) begin
      m_ent[m_cnt] = wif.wr_data;
      m_cnt++;
    end
    m_empty  = (m_cnt == 0);
    m_scroll = !m_empty && run;
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; ena = 1'b1; wif.wr_valid = 1'b0;
    tick(1);
    clear = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; run = 1'b1; speed = 4'd0;
    wif.wr_valid = 1'b0; wif.wr_data = 7'd0;
    model_reset();
    #1;
    total++;
    if ({segments, rd_idx, count, wrap} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got seg=%h idx=%0d cnt=%0d wrap=%b, want all zero",
               segments, rd_idx, count, wrap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (wif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_wr_ready: got %b want 1", wif.wr_ready);
    end
    tick(3);
    total++;
    if (segments !== 7'd0 || count !== 4'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_empty_idle: got seg=%h cnt=%0d wrap=%b want 0/0/0", segments, count, wrap);
    end
  endtask

  task automatic test_basic_scroll();
    logic [6:0] pat [3];
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B;
    run = 1'b1; speed = 4'd0;
    for (int i = 0; i < 3; i++) begin
      wif.wr_valid = 1'b1; wif.wr_data = pat[i];
      tick(1);
      if (i == 1) begin
        total++;
        if (segments !== 7'h3F) begin
          bad++;
          $display("FAIL first_display: got seg=%h want 3f", segments);
        end
      end
    end
    wif.wr_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      total++;
      if (segments !== m_seg || rd_idx !== 3'(m_idx) || count !== 4'(m_cnt) || wrap !== m_wrap) begin
        bad++;
        $display("FAIL basic_scroll c%0d: got seg=%h idx=%0d cnt=%0d wrap=%b want seg=%h idx=%0d cnt=%0d wrap=%b",
                 c, segments, rd_idx, count, wrap, m_seg, m_idx, m_cnt, m_wrap);
      end
    end
  endtask

  task automatic test_speed();
    int last_w, last_i, nwrap;
    logic [2:0] prev_idx;
    do_clear();
    speed = 4'd2; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wif.wr_valid = 1'b1; wif.wr_data = 7'($urandom);
      tick(1);
    end
    wif.wr_valid = 1'b0;
    last_w = -1; last_i = -1; nwrap = 0; prev_idx = rd_idx;
    for (int c = 0; c < 90; c++) begin
      tick(1);
      if (wrap === 1'b1) begin
        nwrap++;
        if (last_w >= 0) begin
          total++;
          if (c - last_w != 24) begin
            bad++;
            $display("FAIL wrap_period: got %0d cycles want 24", c - last_w);
          end
        end
        last_w = c;
      end
      if (rd_idx !== prev_idx) begin
        if (last_i >= 0) begin
          total++;
          if (c - last_i != 12) begin
            bad++;
            $display("FAIL step_period: got %0d cycles want 12", c - last_i);
          end
        end
        last_i = c;
        prev_idx = rd_idx;
      end
    end
    total++;
    if (nwrap < 3) begin
      bad++;
      $display("FAIL wrap_seen: got %0d wraps want >=3", nwrap);
    end
  endtask

  task automatic test_full();
    do_clear();
    speed = 4'd0; run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wif.wr_valid = 1'b1; wif.wr_data = 7'($urandom);
      #1;
      total++;
      if (wif.wr_ready !== (i < 8)) begin
        bad++;
        $display("FAIL full_wr_ready w%0d: got %b want %b", i, wif.wr_ready, (i < 8));
      end
      tick(1);
    end
    wif.wr_valid = 1'b0;
    total++;
    if (count !== 4'd8) begin
      bad++;
      $display("FAIL full_count: got %0d want 8", count);
    end
    for (int c = 0; c < 40; c++) begin
      tick(1);
      total++;
      if (segments !== m_seg || rd_idx !== 3'(m_idx) || wrap !== m_wrap) begin
        bad++;
        $display("FAIL full_scroll c%0d: got seg=%h idx=%0d wrap=%b want seg=%h idx=%0d wrap=%b",
                 c, segments, rd_idx, wrap, m_seg, m_idx, m_wrap);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0] start_idx;
    int n;
    do_clear();
    speed = 4'd1; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wif.wr_valid = 1'b1; wif.wr_data = 7'($urandom);
      tick(1);
    end
    wif.wr_valid = 1'b0;
    start_idx = rd_idx;
    n = 0;
    while (rd_idx === start_idx && n < 40) begin tick(1); n++; end
    tick(3);
    run = 1'b0;
    tick(10);
    run = 1'b1;
    start_idx = rd_idx;
    n = 0;
    while (rd_idx === start_idx && n < 40) begin tick(1); n++; end
    total++;
    if (13 + n != 18) begin
      bad++;
      $display("FAIL hold_delay: got step %0d cycles after previous want 18", 13 + n);
    end
  endtask

  task automatic test_ena_freeze();
    logic [14:0] snap;
    snap = {segments, rd_idx, count, wrap};
    ena = 1'b0; wif.wr_valid = 1'b1; wif.wr_data = 7'h55;
    for (int c = 0; c < 15; c++) begin
      #1;
      total++;
      if (wif.wr_ready !== 1'b0 || {segments, rd_idx, count, wrap} !== snap) begin
        bad++;
        $display("FAIL ena_freeze c%0d: got rdy=%b state=%h want rdy=0 state=%h",
                 c, wif.wr_ready, {segments, rd_idx, count, wrap}, snap);
      end
      tick(1);
    end
    ena = 1'b1; wif.wr_valid = 1'b0;
  endtask

  task automatic test_clear_write();
    wif.wr_valid = 1'b1; wif.wr_data = 7'h7F; clear = 1'b1; run = 1'b1;
    #1;
    total++;
    if (wif.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_wr_ready: got %b want 0", wif.wr_ready);
    end
    tick(1);
    clear = 1'b0; wif.wr_valid = 1'b0;
    total++;
    if (count !== 4'd0 || rd_idx !== 3'd0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL clear_state: got cnt=%0d idx=%0d wrap=%b want 0/0/0", count, rd_idx, wrap);
    end
    tick(1);
    total++;
    if (segments !== 7'd0) begin
      bad++;
      $display("FAIL clear_segments: got %h want 00", segments);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_clear();
    speed = 4'd0; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wif.wr_valid = 1'b1; wif.wr_data = 7'($urandom_range(1, 127));
      tick(1);
    end
    wif.wr_valid = 1'b0;
    n = 0;
    while (rd_idx !== 3'd2 && n < 40) begin tick(1); n++; end
    total++;
    if (rd_idx !== 3'd2 || count !== 4'd3) begin
      bad++;
      $display("FAIL reset_mid_setup: got idx=%0d cnt=%0d want 2/3", rd_idx, count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({segments, rd_idx, count, wrap} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got seg=%h idx=%0d cnt=%0d wrap=%b want zeros",
               segments, rd_idx, count, wrap);
    end
    @(posedge clk); #1;
    total++;
    if (wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wrap: got %b want 0", wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      total++;
      if ({segments, rd_idx, count, wrap} !== 15'd0) begin
        bad++;
        $display("FAIL reset_mid_empty c%0d: got seg=%h idx=%0d cnt=%0d wrap=%b want zeros",
                 c, segments, rd_idx, count, wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      ena          = ($urandom_range(0, 7) != 0);
      clear        = ($urandom_range(0, 39) == 0);
      wif.wr_valid = ($urandom_range(0, 3) == 0);
      wif.wr_data  = 7'($urandom);
      run          = ($urandom_range(0, 5) != 0);
      if (clear && ena) speed = 4'($urandom_range(0, 2));
      #1;
      total++;
      if (wif.wr_ready !== (ena && !clear && m_cnt < 8)) begin
        bad++;
        $display("FAIL rand_wr_ready c%0d: got %b want %b", c, wif.wr_ready, (ena && !clear && m_cnt < 8));
      end
      tick(1);
      total++;
      if (segments !== m_seg || rd_idx !== 3'(m_idx) || count !== 4'(m_cnt) || wrap !== m_wrap) begin
        bad++;
        $display("FAIL rand_outputs c%0d: got seg=%h idx=%0d cnt=%0d wrap=%b want seg=%h idx=%0d cnt=%0d wrap=%b",
                 c, segments, rd_idx, count, wrap, m_seg, m_idx, m_cnt, m_wrap);
      end
    end
    ena = 1'b1; clear = 1'b0; wif.wr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scroll();
    test_speed();
    test_full();
    test_hold();
    test_ena_freeze();
    test_clear_write();
    test_reset_mid();
    do_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
